// File: rtl/noc_arb_pkg.sv
// Shared arbitration types and constants for the mesh router output-port arbiters.
// Port indices are common with the router so grant vectors line up with port numbering.
package noc_arb_pkg;

  // Arbitration mode, selected per instance through LOCK_EN.
  localparam int ARB_HOLD = 0;
  localparam int ARB_LOCK = 1;

  // Router port indices; index 0 is always the local injection port.
  localparam int P_LOCAL = 0;
  localparam int P_N     = 1;
  localparam int P_E     = 2;
  localparam int P_S     = 3;
  localparam int P_W     = 4;
  localparam int N_PORTS = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Per-cycle decision taken by the arbiter at the next clock edge.
  typedef enum logic [2:0] {
    ACT_KEEP,
    ACT_GRANT,
    ACT_IDLE,
    ACT_INC,
    ACT_WRAP
  } arb_act_e;

  // Hold counter must represent 0..HOLD_MAX-1 with headroom for the compare.
  function automatic int cnt_width(input int hold_max);
    return $clog2(hold_max) + 1;
  endfunction

endpackage

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the input-port requesters and one output-port arbiter.
interface rr_hold_arbiter_if #(
  parameter int N_REQ = 5
);
  localparam int CW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] last;
  logic             en;
  logic [N_REQ-1:0] gnt;
  logic             gnt_vld;
  logic [CW-1:0]    gnt_idx;

  modport master (
    output req, last, en,
    input  gnt, gnt_vld, gnt_idx
  );

  modport slave (
    input  req, last, en,
    output gnt, gnt_vld, gnt_idx
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first eligible requester at or after ptr, with modulo wrap.
module rr_pick #(
  parameter int N_REQ = 5,
  parameter int CW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [CW-1:0]    ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [CW-1:0]    pick_idx,
  output logic             pick_vld
);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] rot;
  logic [CW-1:0]    off;
  logic [CW:0]      sum;

  assign elig = req & ~mask;

  // rot[k] is elig[(ptr + k) mod N_REQ]; the left shift supplies the wrapped part.
  assign rot = (elig >> ptr) | (elig << (N_REQ - int'(ptr)));

  // NOTE: off gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = CW'(k);
    end
  end

  assign pick_vld = |elig;
  assign sum      = {1'b0, ptr} + {1'b0, off};
  assign pick_idx = (sum >= (CW+1)'(N_REQ)) ? CW'(sum - (CW+1)'(N_REQ)) : sum[CW-1:0];

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin output-port arbiter with a bounded hold quantum (HOLD) or packet lock (LOCK).
// en=0 freezes everything except the release of an owner that dropped its request.
module rr_hold_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_REQ    = 5,
  parameter int HOLD_MAX = 5,
  parameter int LOCK_EN  = ARB_HOLD
) (
  input logic              clk,
  input logic              rst_n,
  rr_hold_arbiter_if.slave bus
);

  localparam int              CW       = $clog2(N_REQ);
  localparam int              NW       = cnt_width(HOLD_MAX);
  localparam logic [NW-1:0]   CNT_LAST = NW'(HOLD_MAX - 1);
  localparam logic [CW-1:0]   IDX_LAST = CW'(N_REQ - 1);

  arb_state_e       state;
  arb_act_e         act;
  logic [N_REQ-1:0] gnt_q;
  logic [CW-1:0]    own;
  logic [CW-1:0]    ptr;
  logic [NW-1:0]    cnt;

  logic [N_REQ-1:0] own_mask;
  logic             own_req;
  logic             own_last;
  logic [CW-1:0]    pick_idx;
  logic             pick_vld;
  logic [N_REQ-1:0] pick_gnt;
  logic [CW-1:0]    pick_ptr;

  // gnt_q is the one-hot owner, so it doubles as the owner mask and request/tail selector.
  assign own_mask = (state == ST_GRANT) ? gnt_q : '0;
  assign own_req  = |(bus.req & gnt_q);
  assign own_last = |(bus.last & gnt_q);

  rr_pick #(
    .N_REQ (N_REQ),
    .CW    (CW)
  ) u_pick (
    .req      (bus.req),
    .ptr      (ptr),
    .mask     (own_mask),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  assign pick_gnt = N_REQ'(1) << pick_idx;
  assign pick_ptr = (pick_idx == IDX_LAST) ? '0 : pick_idx + CW'(1);

  always_comb begin
    act = ACT_KEEP;
    case (state)
      ST_IDLE: begin
        if (bus.en && pick_vld) act = ACT_GRANT;
      end
      ST_GRANT: begin
        if (!own_req) begin
          // A dropped request releases even while frozen; a waiting requester takes over at once.
          act = (bus.en && pick_vld) ? ACT_GRANT : ACT_IDLE;
        end else if (bus.en) begin
          if (LOCK_EN == ARB_LOCK) begin
            if (own_last) act = pick_vld ? ACT_GRANT : ACT_IDLE;
          end else if (cnt != CNT_LAST) begin
            act = ACT_INC;
          end else begin
            act = pick_vld ? ACT_GRANT : ACT_WRAP;
          end
        end
      end
      default: act = ACT_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt_q <= '0;
      own   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (act)
        ACT_GRANT: begin
          state <= ST_GRANT;
          gnt_q <= pick_gnt;
          own   <= pick_idx;
          ptr   <= pick_ptr;
          cnt   <= '0;
        end
        ACT_IDLE: begin
          state <= ST_IDLE;
          gnt_q <= '0;
          own   <= '0;
          cnt   <= '0;
        end
        ACT_INC:  cnt <= cnt + 1'b1;
        ACT_WRAP: cnt <= '0;
        default:  ;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = (state == ST_GRANT);
  assign bus.gnt_idx = own;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_vld_matches : assert property (@(posedge clk) disable iff (!rst_n)
                                   ((state == ST_GRANT) == (|gnt_q)));
  a_idx_idle    : assert property (@(posedge clk) disable iff (!rst_n)
                                   ((state == ST_IDLE) |-> (own == '0)));
  a_ptr_range   : assert property (@(posedge clk) disable iff (!rst_n) (ptr <= IDX_LAST));

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: one HOLD instance and one LOCK instance, N_REQ=5, HOLD_MAX=5.
module tb_rr_hold_arbiter;
  import noc_arb_pkg::*;

  typedef struct {
    logic [4:0] req;
    logic [4:0] last;
    logic       en;
    logic [4:0] gnt;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  sb_q[$];
  vec_t tbl[14];

  always #5 clk = ~clk;

  rr_hold_arbiter_if #(.N_REQ(5)) hb ();
  rr_hold_arbiter_if #(.N_REQ(5)) lb ();

  rr_hold_arbiter #(.N_REQ(5), .HOLD_MAX(5), .LOCK_EN(ARB_HOLD)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hb)
  );

  rr_hold_arbiter #(.N_REQ(5), .HOLD_MAX(5), .LOCK_EN(ARB_LOCK)) u_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lb)
  );

  // Expected {gnt_vld, gnt_idx, gnt} from an expected grant vector.
  function automatic logic [8:0] expect_of(input logic [4:0] g);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 5; i++) if (g[i]) idx = 3'(i);
    return {|g, idx, g};
  endfunction

  function automatic logic [8:0] dut_out(input bit lock);
    return lock ? {lb.gnt_vld, lb.gnt_idx, lb.gnt} : {hb.gnt_vld, hb.gnt_idx, hb.gnt};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got vld=%b idx=%0d gnt=%b, expected vld=%b idx=%0d gnt=%b",
               name, act[8], act[7:5], act[4:0], exp[8], exp[7:5], exp[4:0]);
    end
  endtask

  // Drive one cycle of stimulus on the chosen instance and score the grant after the edge.
  task automatic step(input bit lock, input logic [4:0] r, input logic [4:0] l, input logic e,
                      input logic [4:0] g, input string name);
    sb_t s;
    @(negedge clk);
    if (lock) begin
      lb.req = r; lb.last = l; lb.en = e;
    end else begin
      hb.req = r; hb.last = l; hb.en = e;
    end
    s.name = name;
    s.exp  = expect_of(g);
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    check(s.name, dut_out(lock), s.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{5'b00100, 5'b00000, 1'b1, 5'b00100};
    tbl[1]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000};
    tbl[2]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000};
    tbl[3]  = '{5'b00001, 5'b00000, 1'b0, 5'b00000};
    tbl[4]  = '{5'b00001, 5'b00000, 1'b1, 5'b00001};
    tbl[5]  = '{5'b00011, 5'b00001, 1'b1, 5'b00001};
    tbl[6]  = '{5'b00010, 5'b00000, 1'b1, 5'b00010};
    tbl[7]  = '{5'b01010, 5'b00010, 1'b1, 5'b00010};
    tbl[8]  = '{5'b01000, 5'b00000, 1'b1, 5'b01000};
    tbl[9]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000};
    tbl[10] = '{5'b10001, 5'b00000, 1'b1, 5'b10000};
    tbl[11] = '{5'b00000, 5'b00000, 1'b1, 5'b00000};
    tbl[12] = '{5'b00011, 5'b00000, 1'b1, 5'b00001};
    tbl[13] = '{5'b00000, 5'b00000, 1'b1, 5'b00000};

    rst_n   = 1'b0;
    hb.req  = 5'($urandom); hb.last = 5'b0; hb.en = 1'b1;
    lb.req  = 5'($urandom); lb.last = 5'b0; lb.en = 1'b1;
    #2;
    check("reset_hold", dut_out(1'b0), expect_of(5'b00000));
    check("reset_lock", dut_out(1'b1), expect_of(5'b00000));
    @(negedge clk);
    rst_n  = 1'b1;
    hb.req = 5'b0;
    lb.req = 5'b0;

    for (int i = 0; i < 14; i++)
      step(1'b0, tbl[i].req, tbl[i].last, tbl[i].en, tbl[i].gnt, $sformatf("tbl[%0d]", i));

    // Reset in the middle of a grant drops it without waiting for an edge.
    step(1'b0, 5'b00100, 5'b0, 1'b1, 5'b00100, "pre_reset_grant");
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    hb.req = 5'($urandom);
    #1;
    check("async_reset_hold", dut_out(1'b0), expect_of(5'b00000));
    @(negedge clk);
    rst_n  = 1'b1;
    hb.req = 5'b0;

    // Full contention: priority restarts at 0, each owner holds exactly 5 cycles.
    for (int e = 1; e <= 31; e++)
      step(1'b0, 5'b11111, 5'b0, 1'b1, 5'b00001 << (((e - 1) / 5) % 5),
           $sformatf("contend[%0d]", e));

    // Sole requester keeps its grant continuously across quantum boundaries.
    for (int e = 1; e <= 20; e++)
      step(1'b0, 5'b01000, 5'b0, 1'b1, 5'b01000, $sformatf("sole[%0d]", e));

    step(1'b0, 5'b00000, 5'b0, 1'b1, 5'b00000, "freeze_idle");
    step(1'b0, 5'b00100, 5'b0, 1'b1, 5'b00100, "freeze_e1");
    step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b00100, "freeze_e2");
    step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b00100, "freeze_e3");
    for (int e = 0; e < 4; e++)
      step(1'b0, 5'b10100, 5'b0, 1'b0, 5'b00100, $sformatf("freeze_off[%0d]", e));
    step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b00100, "freeze_e4");
    step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b00100, "freeze_e5");
    step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b10000, "freeze_switch");
    step(1'b0, 5'b00100, 5'b0, 1'b1, 5'b00100, "release_no_gap");
    step(1'b0, 5'b00000, 5'b0, 1'b0, 5'b00000, "release_while_frozen");
    step(1'b0, 5'b00100, 5'b0, 1'b0, 5'b00000, "idle_frozen");
    step(1'b0, 5'b00100, 5'b0, 1'b1, 5'b00100, "regrant_2");
    for (int e = 1; e <= 4; e++)
      step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b00100, $sformatf("expiry_hold[%0d]", e));
    step(1'b0, 5'b10100, 5'b0, 1'b0, 5'b00100, "expiry_vs_freeze");
    step(1'b0, 5'b10100, 5'b0, 1'b1, 5'b10000, "expiry_switch");
    step(1'b0, 5'b00000, 5'b0, 1'b1, 5'b00000, "hold_done_idle");

    // LOCK: owner 0 holds past any quantum until its tail, other tails are ignored.
    step(1'b1, 5'b10001, 5'b00000, 1'b1, 5'b00001, "lock_grant0");
    for (int e = 0; e < 4; e++)
      step(1'b1, 5'b10001, 5'b10000, 1'b1, 5'b00001, $sformatf("lock_foreign_last[%0d]", e));
    for (int e = 0; e < 4; e++)
      step(1'b1, 5'b10001, 5'b00000, 1'b1, 5'b00001, $sformatf("lock_body[%0d]", e));
    step(1'b1, 5'b10001, 5'b00001, 1'b0, 5'b00001, "lock_last_frozen");
    step(1'b1, 5'b10001, 5'b00001, 1'b1, 5'b10000, "lock_tail_switch");
    for (int e = 0; e < 3; e++)
      step(1'b1, 5'b10000, 5'b00000, 1'b1, 5'b10000, $sformatf("lock_hold4[%0d]", e));
    step(1'b1, 5'b10000, 5'b10000, 1'b1, 5'b00000, "lock_tail_idle");
    step(1'b1, 5'b10000, 5'b00000, 1'b1, 5'b10000, "lock_regrant4");
    step(1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, "lock_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
